usb_rx_ctrl: RTL and testbench
==============================

Name: usb_rx_ctrl

Overview:
- Low-speed USB receive sequencer; sits directly after the cdr block.
- Consumes retimed symbols on each data strobe and performs SYNC detection, NRZI decoding, bit unstuffing, byte assembly (LSB first) and EOP detection.
- Delivers bytes plus packet framing (active / valid / end / error) to the packet decoder.
- Owns the receive state; the cdr block only supplies timing.

Parameters:
- MAX_BYTES, 11, maximum bytes per packet (PID + 8 data + CRC16); exceeding it is babble → error.
- EOP_SE0_MAX, 3, maximum consecutive SE0 strobes accepted within EOP.

Ports:
- clk  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous active-low reset
- rx_enable  in  1  receiver enable; low forces IDLE
- q  in  d_port_t  retimed D+/D- symbol from cdr
- strobe  in  1  one-clk data strobe from cdr (1 per 16 clk)
- rx_data  out  8  assembled byte, valid with rx_valid
- rx_valid  out  1  one-clk pulse per completed byte
- rx_active  out  1  high from end of SYNC until EOP/error/abort
- rx_eop  out  1  one-clk pulse on good end of packet
- rx_error  out  1  one-clk pulse on stuff / babble / EOP / SE1 error

Behaviour:
- Reset: state IDLE; rx_data=8'h00; rx_valid, rx_active, rx_eop, rx_error=0; prev symbol=J; counters=0.
- State and counter updates happen only in clk cycles where strobe=1. Registered outputs change in the cycle after that strobe; pulses last exactly one clk.
- States: IDLE, SYNC, DATA, EOP, ERROR.
- rx_enable=0 in any state:
  - next clk: state goes to IDLE and rx_active=0.
  - No rx_error or rx_eop pulse; a partial byte is discarded.
- IDLE:
  - q==K at strobe → SYNC, sync_cnt=1.
  - Any other symbol → stay in IDLE.
- SYNC:
  - Expected symbols at sync_cnt 1..7 are J,K,J,K,J,K,K.
  - A mismatch returns silently to IDLE (rx_active was never asserted).
  - On the final K: enter DATA, rx_active=1, prev=K, ones_cnt=1 (the trailing KK is a decoded 1), bit_cnt=0, byte_cnt=0.
- DATA, per strobe:
  - q==SE0 → EOP, se0_cnt=1.
  - q==SE1 → ERROR.
  - Otherwise decode: bit = (q==prev), then prev=q.
  - If ones_cnt==6:
    - bit=0 → stuff bit; dropped, ones_cnt=0.
    - bit=1 → stuff error → ERROR.
  - Else: shift bit into shreg[7] (right shift); ones_cnt=bit ? ones_cnt+1 : 0; bit_cnt+1.
  - bit_cnt wraps 7→0: rx_data=shreg, rx_valid pulse, byte_cnt+1.
  - byte_cnt would exceed MAX_BYTES → ERROR (the byte is not presented).
- EOP:
  - Further SE0: se0_cnt+1; se0_cnt>EOP_SE0_MAX → ERROR.
  - q==J: if bit_cnt==0 and byte_cnt>0 → rx_eop pulse, rx_active=0, IDLE; otherwise → ERROR.
  - q==K or SE1 → ERROR.
- ERROR:
  - On entry: rx_error pulse, rx_active=0, partial byte discarded.
  - Stays in ERROR until q==J on 2 consecutive strobes, then IDLE.
- Counter widths: ones_cnt 3b, bit_cnt 3b, sync_cnt 3b, se0_cnt 2b saturating, byte_cnt $clog2(MAX_BYTES+1).
- Simultaneous strobe and rx_enable fall: the abort wins and no byte is emitted.
- Reset asserted mid-packet: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: USB_RX_CRC16_EN.
- Defined:
  - Adds output crc16_ok (1b, reset 0).
  - CRC16 (poly 16'h8005, init 16'hFFFF, LSB-first) runs over decoded, unstuffed bits of all bytes after the first (PID); it is re-initialised when DATA is entered.
  - crc16_ok is registered with rx_eop and is high iff the residual is 16'h800D; it is otherwise 0.
- Undefined: no crc16_ok port and no CRC logic; all other behaviour is identical.

Decomposition:
- Package types (existing) gains:
  - rx_state_t enum {IDLE, SYNC, DATA, EOP, ERROR};
  - localparam SYNC_PATTERN (7 symbols after the first K);
  - CRC16_POLY = 16'h8005;
  - CRC16_RESIDUAL = 16'h800D.
- d_port_t with J, K, SE0 and SE1 is reused from types.
- One sub-module, usb_crc16 (serial 1-bit CRC with clear/enable), is instantiated only under USB_RX_CRC16_EN.

Test Plan:
- SYNC then bytes 8'hC3, 8'h01, 8'h02, then SE0, SE0, J:
  - rx_active rises after the 8th SYNC symbol;
  - rx_valid pulses with 8'hC3, 8'h01, 8'h02;
  - rx_eop pulses once and rx_error stays 0.
- Data byte 8'hFF followed by its stuff bit:
  - the stuffed 0 is removed and rx_data=8'hFF;
  - seven consecutive 1s instead → rx_error pulse, rx_active=0.
- SYNC corrupted (K,J,K,K,…) → no rx_active, no rx_error, returns to IDLE.
- 12 bytes without EOP (MAX_BYTES=11) → 11 rx_valid pulses, then rx_error; exit only after 2 J strobes.
- EOP after 5 bits of a byte, or 4 SE0 strobes → rx_error, no rx_eop.
- rx_enable dropped mid-byte → rx_active falls next clk, no pulses.
- With USB_RX_CRC16_EN: PID 8'hC3, data 8'h00, 8'h01, correct CRC → crc16_ok=1; one data bit flipped → crc16_ok=0.

Source files
------------

// File: rtl/usb_rx_ctrl_pkg.sv
// usb_rx_ctrl_pkg -- shared types and constants for the low-speed USB receive sequencer.
//   d_port_t     : line symbol {D+, D-} as delivered by the cdr block
//   rx_state_t   : receive sequencer states
//   SYNC_PATTERN : the 7 symbols expected after the first K of SYNC (index 0 in bits [1:0])
//   crc16_next   : one serial step of the USB CRC16 (left-shifting form)
package usb_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    J   = 2'b01,
    K   = 2'b10,
    SE1 = 2'b11
  } d_port_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ERROR = 3'd4
  } rx_state_t;

  // Received in order J,K,J,K,J,K,K; the first entry sits in the low bits.
  localparam logic [13:0] SYNC_PATTERN   = {K, K, J, K, J, K, J};
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic d_port_t sync_symbol(input logic [2:0] idx);
    return d_port_t'(SYNC_PATTERN[{idx, 1'b0} +: 2]);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_ctrl_if.sv
// usb_rx_ctrl_if -- bundle between cdr/packet decoder and the receive sequencer.
//   rx_enable, q, strobe               : inputs to the sequencer
//   rx_data, rx_valid, rx_active,
//   rx_eop, rx_error (+ crc16_ok)      : byte stream and framing from the sequencer
// Modport master is the sequencer side, slave the consumer/stimulus side.
// crc16_ok exists only when USB_RX_CRC16_EN is defined.
interface usb_rx_ctrl_if;
  import usb_rx_ctrl_pkg::*;

  logic       rx_enable;
  d_port_t    q;
  logic       strobe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;
`ifdef USB_RX_CRC16_EN
  logic       crc16_ok;
`endif

  modport master (
    input  rx_enable, q, strobe,
`ifdef USB_RX_CRC16_EN
    output crc16_ok,
`endif
    output rx_data, rx_valid, rx_active, rx_eop, rx_error
  );

  modport slave (
    output rx_enable, q, strobe,
`ifdef USB_RX_CRC16_EN
    input  crc16_ok,
`endif
    input  rx_data, rx_valid, rx_active, rx_eop, rx_error
  );

endinterface

// File: rtl/usb_rx_ctrl_crc16.sv
// usb_crc16 -- serial 1-bit CRC16 register (init 16'hFFFF) with clear and enable.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : re-initialise to 16'hFFFF (wins over en)
//   en, din      : shift one data bit into the CRC
//   crc          : current register value
module usb_crc16
  import usb_rx_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 16'hFFFF;
    end else if (clr) begin
      crc <= 16'hFFFF;
    end else if (en) begin
      crc <= crc16_next(crc, din);
    end else begin
      crc <= crc;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl -- low-speed USB receive sequencer: SYNC detect, NRZI decode,
// bit unstuffing, LSB-first byte assembly and EOP detection.
//   clk, reset_n : 24 MHz clock, asynchronous active-low reset
//   bus (master) : rx_enable/q/strobe in; rx_data/rx_valid/rx_active/rx_eop/rx_error out
// Optional macro USB_RX_CRC16_EN adds bus.crc16_ok, checked at good EOP over all
// decoded bits following the PID byte.
module usb_rx_ctrl
  import usb_rx_ctrl_pkg::*;
#(
  parameter int MAX_BYTES   = 11,
  parameter int EOP_SE0_MAX = 3
)
(
  input  logic          clk,
  input  logic          reset_n,
  usb_rx_ctrl_if.master bus
);

  localparam int          BYTE_W    = $clog2(MAX_BYTES + 1);
  localparam logic [1:0]  SE0_LIMIT = EOP_SE0_MAX[1:0];

  rx_state_t         state_r, state_s;
  d_port_t           prev_r, prev_s;
  logic [2:0]        ones_cnt_r, ones_cnt_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [2:0]        sync_cnt_r, sync_cnt_s;
  logic [1:0]        se0_cnt_r, se0_cnt_s;
  logic [BYTE_W-1:0] byte_cnt_r, byte_cnt_s;
  logic [7:0]        shreg_r, shreg_s;
  logic              err_j_r, err_j_s;
  logic [7:0]        rx_data_r, rx_data_s;
  logic              rx_valid_r, rx_valid_s;
  logic              rx_active_r, rx_active_s;
  logic              rx_eop_r, rx_eop_s;
  logic              rx_error_r, rx_error_s;
  logic              dbit_s;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      prev_r      <= J;
      ones_cnt_r  <= 3'd0;
      bit_cnt_r   <= 3'd0;
      sync_cnt_r  <= 3'd0;
      se0_cnt_r   <= 2'd0;
      byte_cnt_r  <= '0;
      shreg_r     <= 8'h00;
      err_j_r     <= 1'b0;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      rx_active_r <= 1'b0;
      rx_eop_r    <= 1'b0;
      rx_error_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      prev_r      <= prev_s;
      ones_cnt_r  <= ones_cnt_s;
      bit_cnt_r   <= bit_cnt_s;
      sync_cnt_r  <= sync_cnt_s;
      se0_cnt_r   <= se0_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      shreg_r     <= shreg_s;
      err_j_r     <= err_j_s;
      rx_data_r   <= rx_data_s;
      rx_valid_r  <= rx_valid_s;
      rx_active_r <= rx_active_s;
      rx_eop_r    <= rx_eop_s;
      rx_error_r  <= rx_error_s;
    end
  end

  // Next-state and next-output decode; nothing advances without a strobe
  always_comb begin
    state_s     = state_r;
    prev_s      = prev_r;
    ones_cnt_s  = ones_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    sync_cnt_s  = sync_cnt_r;
    se0_cnt_s   = se0_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    shreg_s     = shreg_r;
    err_j_s     = err_j_r;
    rx_data_s   = rx_data_r;
    rx_valid_s  = 1'b0;
    rx_active_s = rx_active_r;
    rx_eop_s    = 1'b0;
    rx_error_s  = 1'b0;
    // NRZI: no transition decodes as 1
    dbit_s      = (bus.q == prev_r);

    if (!bus.rx_enable) begin
      // Abort beats a coincident strobe: silent return to IDLE
      state_s     = IDLE;
      rx_active_s = 1'b0;
    end else if (bus.strobe) begin
      case (state_r)
        IDLE: begin
          if (bus.q == K) begin
            state_s    = SYNC;
            sync_cnt_s = 3'd1;
          end else begin
            state_s    = IDLE;
          end
        end
        SYNC: begin
          if (bus.q == sync_symbol(sync_cnt_r - 3'd1)) begin
            if (sync_cnt_r == 3'd7) begin
              // Trailing KK of SYNC is a decoded 1, so stuffing starts at one
              state_s     = DATA;
              rx_active_s = 1'b1;
              prev_s      = K;
              ones_cnt_s  = 3'd1;
              bit_cnt_s   = 3'd0;
              byte_cnt_s  = '0;
            end else begin
              sync_cnt_s  = sync_cnt_r + 3'd1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          case (bus.q)
            SE0: begin
              state_s   = EOP;
              se0_cnt_s = 2'd1;
            end
            SE1: begin
              state_s = ERROR;
            end
            default: begin
              prev_s = bus.q;
              if (ones_cnt_r == 3'd6) begin
                if (dbit_s) begin
                  state_s    = ERROR;
                end else begin
                  ones_cnt_s = 3'd0;
                end
              end else begin
                shreg_s    = {dbit_s, shreg_r[7:1]};
                ones_cnt_s = dbit_s ? (ones_cnt_r + 3'd1) : 3'd0;
                bit_cnt_s  = bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                  if (byte_cnt_r == BYTE_W'(MAX_BYTES)) begin
                    // Babble: the overflowing byte is never presented
                    state_s    = ERROR;
                  end else begin
                    rx_data_s  = shreg_s;
                    rx_valid_s = 1'b1;
                    byte_cnt_s = byte_cnt_r + BYTE_W'(1);
                  end
                end else begin
                  rx_valid_s = 1'b0;
                end
              end
            end
          endcase
        end
        EOP: begin
          case (bus.q)
            SE0: begin
              if (se0_cnt_r >= SE0_LIMIT) begin
                state_s   = ERROR;
              end else begin
                se0_cnt_s = (se0_cnt_r == 2'd3) ? se0_cnt_r : (se0_cnt_r + 2'd1);
              end
            end
            J: begin
              if ((bit_cnt_r == 3'd0) && (byte_cnt_r != '0)) begin
                state_s     = IDLE;
                rx_eop_s    = 1'b1;
                rx_active_s = 1'b0;
              end else begin
                state_s     = ERROR;
              end
            end
            default: begin
              state_s = ERROR;
            end
          endcase
        end
        ERROR: begin
          // Leave only after two J strobes in a row
          if (bus.q == J) begin
            if (err_j_r) begin
              state_s = IDLE;
              err_j_s = 1'b0;
            end else begin
              err_j_s = 1'b1;
            end
          end else begin
            err_j_s = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      // Common ERROR entry: single error pulse, packet dropped
      if ((state_r != ERROR) && (state_s == ERROR)) begin
        rx_error_s  = 1'b1;
        rx_active_s = 1'b0;
        err_j_s     = 1'b0;
      end else begin
        rx_error_s  = 1'b0;
      end
    end else begin
      state_s = state_r;
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.rx_active = rx_active_r;
  assign bus.rx_eop    = rx_eop_r;
  assign bus.rx_error  = rx_error_r;

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc_val;
  logic        crc_clr;
  logic        crc_en;
  logic        crc16_ok_r;

  // Restart on DATA entry; accumulate only real data bits after the PID byte
  assign crc_clr = bus.rx_enable && bus.strobe && (state_r == SYNC) && (state_s == DATA);
  assign crc_en  = bus.rx_enable && bus.strobe && (state_r == DATA) &&
                   ((bus.q == J) || (bus.q == K)) && (ones_cnt_r != 3'd6) &&
                   (byte_cnt_r != '0);

  usb_crc16 u_crc16 (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .din     (dbit_s),
    .crc     (crc_val)
  );

  // CRC verdict, valid only alongside the rx_eop pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc16_ok_r <= 1'b0;
    end else begin
      crc16_ok_r <= rx_eop_s && (crc_val == CRC16_RESIDUAL);
    end
  end

  assign bus.crc16_ok = crc16_ok_r;
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb_usb_rx_ctrl -- directed self-checking bench for usb_rx_ctrl.
// Bench-side NRZI encoder with bit stuffing drives the symbol stream; a monitor
// counts output pulses and each scenario task checks the counts it expects.
module tb_usb_rx_ctrl;
  import usb_rx_ctrl_pkg::*;

  localparam int GAP = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // monitor-owned counters
  int         n_valid = 0;
  int         n_eop   = 0;
  int         n_err   = 0;
  logic [7:0] got[$];
  logic       last_crc_ok = 1'b0;

  // scenario baselines
  int b_valid, b_eop, b_err, b_got;

  // bench encoder state
  d_port_t tb_prev;
  int      tb_ones;

  usb_rx_ctrl_if bus();

  usb_rx_ctrl #(.MAX_BYTES(11), .EOP_SE0_MAX(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      got.push_back(bus.rx_data);
      n_valid++;
    end
    if (bus.rx_eop) n_eop++;
    if (bus.rx_error) n_err++;
`ifdef USB_RX_CRC16_EN
    if (bus.rx_eop) last_crc_ok = bus.crc16_ok;
`endif
  end

  task automatic mark();
    b_valid = n_valid; b_eop = n_eop; b_err = n_err; b_got = got.size();
  endtask

  task automatic send_sym(input d_port_t s);
    @(negedge clk); bus.q = s; bus.strobe = 1'b1;
    @(negedge clk); bus.strobe = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_sync();
    send_sym(K); send_sym(J); send_sym(K); send_sym(J);
    send_sym(K); send_sym(J); send_sym(K); send_sym(K);
    tb_prev = K; tb_ones = 1;
  endtask

  task automatic send_bit(input logic b, input logic stuff_en);
    d_port_t s;
    s = b ? tb_prev : ((tb_prev == J) ? K : J);
    send_sym(s); tb_prev = s;
    if (b) tb_ones++; else tb_ones = 0;
    if (stuff_en && tb_ones == 6) begin
      s = (tb_prev == J) ? K : J;
      send_sym(s); tb_prev = s; tb_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b1);
  endtask

  task automatic send_eop();
    send_sym(SE0); send_sym(SE0); send_sym(J);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.rx_data, bus.rx_valid, bus.rx_active, bus.rx_eop, bus.rx_error} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b a=%b e=%b err=%b want all 0",
               bus.rx_data, bus.rx_valid, bus.rx_active, bus.rx_eop, bus.rx_error);
    end
  endtask

  task automatic test_basic();
    mark();
    send_sym(K); send_sym(J); send_sym(K); send_sym(J);
    send_sym(K); send_sym(J); send_sym(K);
    checks++;
    if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL active_before_sync_end: got %b want 0", bus.rx_active); end
    send_sym(K); tb_prev = K; tb_ones = 1;
    checks++;
    if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL active_after_sync: got %b want 1", bus.rx_active); end
    send_byte(8'hC3); send_byte(8'h01); send_byte(8'h02);
    checks++;
    if (n_valid - b_valid !== 3) begin errors++; $display("FAIL basic_valid_count: got %0d want 3", n_valid - b_valid); end
    else begin
      checks++;
      if ({got[b_got], got[b_got+1], got[b_got+2]} !== 24'hC30102) begin
        errors++; $display("FAIL basic_bytes: got %h %h %h want c3 01 02", got[b_got], got[b_got+1], got[b_got+2]);
      end
    end
    send_eop();
    checks++;
    if (n_eop - b_eop !== 1 || n_err - b_err !== 0 || bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL basic_eop: got eop=%0d err=%0d active=%b want 1 0 0", n_eop - b_eop, n_err - b_err, bus.rx_active);
    end
  endtask

  task automatic test_stuffing();
    mark();
    send_sync(); send_byte(8'hFF); send_eop();
    checks++;
    if (n_valid - b_valid !== 1 || n_eop - b_eop !== 1 || n_err - b_err !== 0) begin
      errors++; $display("FAIL stuff_framing: got valid=%0d eop=%0d err=%0d want 1 1 0", n_valid - b_valid, n_eop - b_eop, n_err - b_err);
    end else begin
      checks++;
      if (got[b_got] !== 8'hFF) begin errors++; $display("FAIL stuff_data: got %h want ff", got[b_got]); end
    end
    mark();
    send_sync();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    checks++;
    if (n_err - b_err !== 1 || bus.rx_active !== 1'b0 || n_valid - b_valid !== 0) begin
      errors++; $display("FAIL stuff_error: got err=%0d active=%b valid=%0d want 1 0 0", n_err - b_err, bus.rx_active, n_valid - b_valid);
    end
    send_sym(J); send_sym(J);
  endtask

  task automatic test_bad_sync();
    mark();
    send_sym(K); send_sym(J); send_sym(K); send_sym(K);
    send_sym(J); send_sym(K); send_sym(J); send_sym(J);
    send_sym(J); send_sym(J);
    checks++;
    if (bus.rx_active !== 1'b0 || n_err - b_err !== 0 || n_valid - b_valid !== 0) begin
      errors++; $display("FAIL bad_sync: got active=%b err=%0d valid=%0d want 0 0 0", bus.rx_active, n_err - b_err, n_valid - b_valid);
    end
  endtask

  task automatic test_babble();
    mark();
    send_sync();
    for (int i = 0; i < 11; i++) send_byte(8'h10 + 8'(i));
    checks++;
    if (n_valid - b_valid !== 11 || n_err - b_err !== 0) begin
      errors++; $display("FAIL babble_11: got valid=%0d err=%0d want 11 0", n_valid - b_valid, n_err - b_err);
    end else begin
      checks++;
      if (got[b_got+10] !== 8'h1A) begin errors++; $display("FAIL babble_last_byte: got %h want 1a", got[b_got+10]); end
    end
    send_byte(8'h1B);
    checks++;
    if (n_valid - b_valid !== 11 || n_err - b_err !== 1 || bus.rx_active !== 1'b0) begin
      errors++; $display("FAIL babble_error: got valid=%0d err=%0d active=%b want 11 1 0", n_valid - b_valid, n_err - b_err, bus.rx_active);
    end
    // one J then a SYNC: no two consecutive Js, so still in ERROR
    send_sym(J); send_sync();
    checks++;
    if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL babble_exit_early: got active=%b want 0", bus.rx_active); end
    send_sym(J); send_sym(J); send_sync();
    checks++;
    if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL babble_exit: got active=%b want 1", bus.rx_active); end
    @(negedge clk); bus.rx_enable = 1'b0;
    @(negedge clk); bus.rx_enable = 1'b1;
  endtask

  task automatic test_eop_errors();
    mark();
    send_sync(); send_byte(8'hC3);
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
    send_eop();
    checks++;
    if (n_err - b_err !== 1 || n_eop - b_eop !== 0) begin
      errors++; $display("FAIL eop_partial: got err=%0d eop=%0d want 1 0", n_err - b_err, n_eop - b_eop);
    end
    send_sym(J); send_sym(J);
    mark();
    send_sync(); send_byte(8'hC3);
    send_sym(SE0); send_sym(SE0); send_sym(SE0);
    checks++;
    if (n_err - b_err !== 0) begin errors++; $display("FAIL eop_three_se0: got err=%0d want 0", n_err - b_err); end
    send_sym(SE0);
    checks++;
    if (n_err - b_err !== 1 || n_eop - b_eop !== 0) begin
      errors++; $display("FAIL eop_four_se0: got err=%0d eop=%0d want 1 0", n_err - b_err, n_eop - b_eop);
    end
    send_sym(J); send_sym(J);
  endtask

  task automatic test_abort();
    d_port_t s;
    mark();
    send_sync();
    for (int i = 0; i < 7; i++) send_bit(i[0], 1'b1);
    // 8th bit strobe coincides with the enable fall
    s = (tb_prev == J) ? K : J;
    @(negedge clk); bus.q = s; bus.strobe = 1'b1; bus.rx_enable = 1'b0;
    @(negedge clk); bus.strobe = 1'b0;
    checks++;
    if (bus.rx_active !== 1'b0 || bus.rx_valid !== 1'b0) begin
      errors++; $display("FAIL abort_coincident: got active=%b valid=%b want 0 0", bus.rx_active, bus.rx_valid);
    end
    repeat (GAP) @(negedge clk);
    bus.rx_enable = 1'b1;
    send_sym(J);
    send_sync(); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1);
    checks++;
    if (bus.rx_active !== 1'b1) begin errors++; $display("FAIL abort_pre_active: got %b want 1", bus.rx_active); end
    @(negedge clk); bus.rx_enable = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rx_active !== 1'b0) begin errors++; $display("FAIL abort_midbyte: got active=%b want 0", bus.rx_active); end
    repeat (GAP) @(negedge clk);
    bus.rx_enable = 1'b1;
    checks++;
    if (n_valid - b_valid !== 0 || n_err - b_err !== 0 || n_eop - b_eop !== 0) begin
      errors++; $display("FAIL abort_pulses: got valid=%0d err=%0d eop=%0d want 0 0 0", n_valid - b_valid, n_err - b_err, n_eop - b_eop);
    end
    send_sym(J);
  endtask

  task automatic test_async_reset();
    send_sync(); send_byte(8'hC3);
    @(negedge clk); #5 reset_n = 1'b0; #1;
    checks++;
    if (bus.rx_active !== 1'b0 || bus.rx_data !== 8'h00) begin
      errors++; $display("FAIL async_reset: got active=%b data=%h want 0 00", bus.rx_active, bus.rx_data);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef USB_RX_CRC16_EN
  function automatic logic [15:0] model_crc(input logic [7:0] d0, input logic [7:0] d1);
    logic [15:0] c;
    logic [15:0] msg;
    logic        fb;
    c = 16'hFFFF;
    msg = {d1, d0};
    for (int i = 0; i < 16; i++) begin
      fb = msg[i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  task automatic test_crc16();
    logic [15:0] c;
    c = model_crc(8'h00, 8'h01);
    mark();
    send_sync(); send_byte(8'hC3); send_byte(8'h00); send_byte(8'h01);
    for (int i = 15; i >= 0; i--) send_bit(~c[i], 1'b1);
    send_eop();
    checks++;
    if (n_eop - b_eop !== 1 || last_crc_ok !== 1'b1) begin
      errors++; $display("FAIL crc_good: got eop=%0d ok=%b want 1 1", n_eop - b_eop, last_crc_ok);
    end
    mark();
    send_sync(); send_byte(8'hC3); send_byte(8'h04); send_byte(8'h01);
    for (int i = 15; i >= 0; i--) send_bit(~c[i], 1'b1);
    send_eop();
    checks++;
    if (n_eop - b_eop !== 1 || last_crc_ok !== 1'b0) begin
      errors++; $display("FAIL crc_bad: got eop=%0d ok=%b want 1 0", n_eop - b_eop, last_crc_ok);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    bus.q = J; bus.strobe = 1'b0; bus.rx_enable = 1'b1;
    tb_prev = J; tb_ones = 0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_stuffing();
    test_bad_sync();
    test_babble();
    test_eop_errors();
    test_abort();
`ifdef USB_RX_CRC16_EN
    test_crc16();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
